// File: rtl/c17_bist_pkg.sv
// Shared types, widths, tap masks and the LFSR step for the c17 BIST controller.
package c17_bist_pkg;
  localparam int CUT_IN_W  = 5;
  localparam int CUT_OUT_W = 2;
  localparam int MISR_W    = 8;

  // Feedback taps: LFSR x^5+x^3+1 (bits 4,2); MISR bits 7,5,4,3.
  localparam logic [CUT_IN_W-1:0] LFSR_TAPS = 5'b10100;
  localparam logic [MISR_W-1:0]   MISR_TAPS = 8'b10111000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } bist_state_t;

  function automatic logic [CUT_IN_W-1:0] lfsr_next(input logic [CUT_IN_W-1:0] v);
    return {v[CUT_IN_W-2:0], ^(v & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/c17_bist_misr.sv
// 8-bit multiple-input signature register compacting the 2-bit CUT response.
module c17_bist_misr
  import c17_bist_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_clear,
  input  logic                 i_enable,
  input  logic [CUT_OUT_W-1:0] i_data,
  output logic [MISR_W-1:0]    o_sig
);
  logic [MISR_W-1:0] r_sig;

  // Clear wins over enable; otherwise shift with feedback and fold in the response.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)      r_sig <= '0;
    else if (i_clear)  r_sig <= '0;
    else if (i_enable) r_sig <= {r_sig[MISR_W-2:0], ^(r_sig & MISR_TAPS)}
                                ^ {{(MISR_W-CUT_OUT_W){1'b0}}, i_data};
  end

  assign o_sig = r_sig;
endmodule

// File: rtl/c17_bist_ctrl.sv
// BIST controller for c17: LFSR pattern source, MISR compaction, golden compare.
module c17_bist_ctrl
  import c17_bist_pkg::*;
#(
  parameter int unsigned          N_PAT  = 31,
  parameter logic [CUT_IN_W-1:0]  SEED   = 5'h01,
  parameter logic [MISR_W-1:0]    GOLDEN = 8'h00
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic                 i_abort,
  output logic [CUT_IN_W-1:0]  o_cut_in,
  input  logic [CUT_OUT_W-1:0] i_cut_out,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_pass,
  output logic [MISR_W-1:0]    o_signature,
  output logic [4:0]           o_pat_cnt
);
  localparam logic [4:0] LAST_CNT = 5'(N_PAT - 1);

  bist_state_t         r_state, w_next;
  logic                w_load, w_comp;
  logic [CUT_IN_W-1:0] r_lfsr, r_cut_in, w_lfsr_nxt;
  logic [4:0]          r_pat_cnt;
  logic                r_pass;
  logic [MISR_W-1:0]   w_sig;

  assign w_lfsr_nxt = lfsr_next(r_lfsr);

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Next state; start only seen in IDLE/DONE, abort only in RUN/CHECK and
  // ahead of the RUN->CHECK step.
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_comp = 1'b0;
    case (r_state)
      IDLE, DONE: if (i_start) begin
        w_next = RUN;
        w_load = 1'b1;
      end
      RUN: if (i_abort) w_next = IDLE;
           else begin
             w_comp = 1'b1;
             if (r_pat_cnt == LAST_CNT) w_next = CHECK;
           end
      CHECK: w_next = i_abort ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end

  // Pattern source, counter and verdict. cut_in is a flop that mirrors the
  // LFSR while running and is zero everywhere else.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lfsr    <= SEED;
      r_cut_in  <= '0;
      r_pat_cnt <= '0;
      r_pass    <= 1'b0;
    end else if (w_load) begin
      r_lfsr    <= SEED;
      r_cut_in  <= SEED;
      r_pat_cnt <= '0;
      r_pass    <= 1'b0;
    end else if (w_comp) begin
      r_lfsr    <= w_lfsr_nxt;
      r_cut_in  <= (w_next == RUN) ? w_lfsr_nxt : '0;
      r_pat_cnt <= r_pat_cnt + 5'd1;
    end else begin
      r_cut_in  <= '0;
      if (r_state == CHECK) r_pass <= !i_abort && (w_sig == GOLDEN);
    end
  end

  c17_bist_misr u_misr (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clear  (w_load),
    .i_enable (w_comp),
    .i_data   (i_cut_out),
    .o_sig    (w_sig)
  );

  assign o_cut_in    = r_cut_in;
  assign o_busy      = (r_state == RUN) || (r_state == CHECK);
  assign o_done      = (r_state == DONE);
  assign o_pass      = r_pass && o_done;
  assign o_signature = w_sig;
  assign o_pat_cnt   = r_pat_cnt;
endmodule

// File: tb/tb_c17_bist_ctrl.sv
// Directed bench for c17_bist_ctrl with a behavioural c17 attached.
module tb_c17_bist_ctrl;
  // c17 gate-level reference: inputs {G7,G6,G3,G2,G1}, outputs {G23,G22}.
  function automatic logic [1:0] c17(input logic [4:0] v);
    logic g10, g11, g16, g19;
    g10 = ~(v[0] & v[2]);
    g11 = ~(v[2] & v[3]);
    g16 = ~(v[1] & g11);
    g19 = ~(g11 & v[4]);
    return {~(g16 & g19), ~(g10 & g16)};
  endfunction

  // Reference signature after n patterns from seed 1, optional G22 stuck-at-0.
  function automatic logic [7:0] model_sig(input int n, input bit sa0);
    logic [4:0] l;
    logic [7:0] m;
    logic [1:0] o;
    l = 5'h01;
    m = 8'h00;
    for (int i = 0; i < n; i++) begin
      o = c17(l);
      if (sa0) o[0] = 1'b0;
      m = {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]} ^ {6'b0, o};
      l = {l[3:0], l[4] ^ l[2]};
    end
    return m;
  endfunction

  localparam logic [7:0] GOLD = model_sig(31, 1'b0);

  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, sa0 = 1'b0;
  logic [4:0] cut_in, pat_cnt;
  logic [1:0] cut_out;
  logic       busy, done, pass;
  logic [7:0] signature;
  int         n_chk = 0, n_err = 0;
  logic [31:0] seen;
  int         dups, guard;

  always #5 clk = ~clk;

  always_comb begin
    cut_out = c17(cut_in);
    if (sa0) cut_out[0] = 1'b0;
  end

  c17_bist_ctrl #(.N_PAT(31), .SEED(5'h01), .GOLDEN(GOLD)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
    .o_cut_in(cut_in), .i_cut_out(cut_out), .o_busy(busy), .o_done(done),
    .o_pass(pass), .o_signature(signature), .o_pat_cnt(pat_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ne(input string tag, input logic [31:0] obs, input logic [31:0] bad);
    n_chk++;
    assert (obs !== bad) else begin
      n_err++;
      $error("FAIL %s observed=%0h must differ from %0h", tag, obs, bad);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_vec"}, {cut_in, busy, done, pass, signature, pat_cnt}, 32'h0);
  endtask

  initial begin
    // Reset held while start toggles.
    #2;
    for (int i = 0; i < 4; i++) begin
      start = ~start;
      step();
    end
    start = 1'b0;
    chk_all_zero("rst_hold");
    #2 rst_n = 1'b1;
    step(); step(); step();
    chk_all_zero("rst_idle");

    // Full run with a stray start pulse mid-RUN.
    seen = '0;
    dups = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 33; c++) begin
      if (c <= 31) begin
        if (seen[cut_in]) dups++;
        seen[cut_in] = 1'b1;
        chk("run_busy", {31'b0, busy}, 32'h1);
      end
      if (c == 1) begin
        chk("c1_cut_in", cut_in, 5'h01);
        chk("c1_cut_out", cut_out, 2'b00);
        chk("c1_sig", signature, 8'h00);
        chk("c1_cnt", pat_cnt, 5'd0);
      end
      if (c == 2) begin
        chk("c2_cut_in", cut_in, 5'h02);
        chk("c2_cut_out", cut_out, 2'b11);
        chk("c2_sig", signature, 8'h00);
      end
      if (c == 3) chk("c3_sig", signature, 8'h03);
      if (c == 11) chk("c11_sig", signature, model_sig(10, 1'b0));
      if (c == 32) begin
        chk("check_busy_done", {busy, done, pass}, 3'b100);
        chk("check_cut_in", cut_in, 5'h00);
        chk("check_cnt", pat_cnt, 5'd31);
      end
      if (c == 33) begin
        chk("done_flags", {busy, done, pass}, 3'b011);
        chk("done_cnt", pat_cnt, 5'd31);
        chk("done_sig", signature, GOLD);
        chk("done_cut_in", cut_in, 5'h00);
      end
      start = (c == 5);
      if (c < 33) step();
    end
    chk("lfsr_cover", seen, 32'hFFFF_FFFE);
    chk("lfsr_dups", dups, 0);
    step(); step(); step();
    chk("done_hold", {busy, done, pass, pat_cnt}, {3'b011, 5'd31});
    chk("done_hold_sig", signature, GOLD);

    // Start from DONE, G22 stuck-at-0.
    sa0 = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_flags", {busy, done, pass}, 3'b100);
    chk("restart_state", {cut_in, signature, pat_cnt}, {5'h01, 8'h00, 5'd0});
    for (int c = 2; c <= 33; c++) step();
    chk("sa0_flags", {busy, done, pass}, 3'b010);
    chk("sa0_sig", signature, model_sig(31, 1'b1));
    chk_ne("sa0_sig_ne_gold", signature, GOLD);

    // Abort at pat_cnt==10.
    sa0 = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    guard = 0;
    while (pat_cnt != 5'd10 && guard < 40) begin
      step();
      guard++;
    end
    chk("abort_reach10", pat_cnt, 5'd10);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_flags", {busy, done, pass}, 3'b000);
    chk("abort_cut_in", cut_in, 5'h00);
    chk("abort_cnt", pat_cnt, 5'd10);
    chk("abort_sig", signature, model_sig(10, 1'b0));
    step();
    chk("abort_stay_idle", {busy, done, pat_cnt}, {2'b00, 5'd10});

    // Start and abort together in IDLE: start wins.
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    chk("rerun_flags", {busy, done}, 2'b10);
    chk("rerun_state", {cut_in, signature, pat_cnt}, {5'h01, 8'h00, 5'd0});

    // Asynchronous reset mid-run.
    for (int i = 0; i < 7; i++) step();
    chk("pre_rst_cnt", pat_cnt, 5'd7);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    #3 rst_n = 1'b1;
    step();
    chk_all_zero("post_rst_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
